exec_pipe_v3: RTL and testbench
===============================

Name: exec_pipe_v3

Overview:
Parametrised execute/writeback datapath that succeeds the fixed 32-bit single-issue regfile + operand mux + ALU integration. It accepts decoded operations over a valid/ready handshake and reads operands from an internal NUM_REGS x XLEN register file, forwarding the in-flight writeback value. It computes the result in one stage and holds it in a writeback register until the downstream result handshake completes, then commits it to the register file. It sits between the decoder and the instruction-fetch/sequencer; op_done replaces the old single-cycle ALU acknowledge.

Parameters:
XLEN, 32, datapath and register width (>= 8)
NUM_REGS, 32, architectural register count (power of two, >= 2); register 0 reads as zero
CNT_W, 16, width of the retired-operation counter
(derived, not overridable) ADDR_W = $clog2(NUM_REGS); SH_W = $clog2(XLEN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  decoded operation valid
in_ready  out  1  block can accept an operation this cycle
in_opcode  in  4  {funct7[5], funct3}
in_rs1  in  ADDR_W  source register 1
in_rs2  in  ADDR_W  source register 2
in_rd  in  ADDR_W  destination register
in_imm  in  XLEN  sign-extended immediate
in_rd2_imme_sel  in  1  1 = operand B from rs2, 0 = operand B from in_imm
in_rd_wr_en  in  1  commit result to in_rd
res_valid  out  1  writeback stage holds a result
res_ready  in  1  downstream accepts the result
res_data  out  XLEN  result value
res_rd  out  ADDR_W  destination of held result
op_done  out  1  one-cycle pulse on commit (res_valid & res_ready)
retired_cnt  out  CNT_W  number of committed operations
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  XLEN  combinational register read; 0 for address 0

Behaviour:
- Reset (async, active-high): all registers = 0; wb_valid = 0; retired_cnt = 0. Outputs go to res_valid=0, res_data=0, res_rd=0, op_done=0, in_ready=1. A reset asserted mid-operation discards the held result without committing it.
- in_ready = !wb_valid | res_ready. An operation is accepted when in_valid & in_ready.
- Operand read is combinational at acceptance. A = rf[in_rs1] and B = rf[in_rs2] or in_imm, selected by in_rd2_imme_sel. Register 0 always reads 0.
- Forwarding: if wb_valid & wb_wr_en & (wb_rd == rsX) & (rsX != 0), rsX takes wb_data. This applies because, whenever an operation is accepted, the WB entry is either empty or committing in the same cycle.
- ALU ops (result is XLEN bits, wraps modulo 2^XLEN):
  - 0000 ADD; 1000 SUB; 0001 SLL; 0010 SLT (signed); 0011 SLTU; 0100 XOR; 0101 SRL; 1101 SRA; 0110 OR; 0111 AND.
  - Shifts use B[SH_W-1:0].
  - Any other code gives result 0, which is handled and committed like a legal op.
- Latency: an operation accepted in cycle N has res_valid=1 in cycle N+1. It commits on the first cycle k >= N+1 with res_ready=1.
- Commit (res_valid & res_ready):
  - rf[wb_rd] <= wb_data if wb_wr_en and wb_rd != 0.
  - op_done = 1 in that cycle, combinational with the handshake.
  - retired_cnt increments by 1 and wraps at 2^CNT_W.
- WB register update each cycle:
  - Accept: load the new result; wb_valid = 1.
  - Else, on commit: wb_valid = 0.
  - Else: hold. res_data and res_rd stay stable while res_valid & !res_ready.
- Simultaneous commit and accept: full throughput, one op per cycle, no bubble.
- A write to rd 0 is suppressed but still counts as retired and still pulses op_done.
- dbg_data reflects the register file before the current cycle's commit. It does not see forwarded values.

Test Plan:
- Reset then ADDI (op 0000, rs1=0, imm=5, sel=0, rd=1, wr_en=1), res_ready=1 -> res_valid cycle+1 with res_data=5, op_done=1, dbg_addr=1 reads 5 next cycle, retired_cnt=1.
- Back-to-back dependency: r1=5, then ADD rd=2 rs1=1 rs2=1 (sel=1) accepted while r1 commits -> res_data=10 via forwarding, no stall.
- Backpressure: hold res_ready=0 for 3 cycles with result 0x7 pending and next op valid -> in_ready=0, res_data stays 0x7, regfile unchanged; release -> commit then accept the next op in the same cycle.
- Arithmetic edges (XLEN=32): SUB 0-1 = 0xFFFFFFFF; SLT(-1,1)=1; SLTU(0xFFFFFFFF,1)=0; SRA(0x80000000,31)=0xFFFFFFFF; SLL by B=33 = shift by 1.
- Rd 0 and illegal opcode: ADD to rd=0 -> r0 still reads 0, op_done pulses, retired_cnt increments. Opcode 1111 -> res_data=0.
- Reset mid-operation: assert reset while res_valid=1, res_ready=0 -> res_valid drops immediately, no register written, retired_cnt=0; repeat with NUM_REGS=8, XLEN=16 to cover the parametrised build.

Source files
------------

// File: rtl/exec_pipe_v3.sv
// Execute/writeback datapath: register file with operand forwarding, single-cycle ALU,
// and a writeback register held until the result handshake commits it.
module exec_pipe_v3 #(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    parameter  int CNT_W    = 16,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    localparam int SH_W     = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_rd2_imme_sel,
    input  logic              in_rd_wr_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [XLEN-1:0]   res_data,
    output logic [ADDR_W-1:0] res_rd,
    output logic              op_done,
    output logic [CNT_W-1:0]  retired_cnt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b1000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SRA  = 4'b1101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111
    } alu_op_e;

    logic [XLEN-1:0]   rf [NUM_REGS];

    logic              wb_valid;
    logic [XLEN-1:0]   wb_data;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_wr_en;

    logic              accept;
    logic              commit;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   op_b;
    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   alu_result;

    // An accepted op always finds WB empty or draining this cycle, so one stage suffices.
    assign in_ready = !wb_valid || res_ready;
    assign accept   = in_valid && in_ready;
    assign commit   = wb_valid && res_ready;

    // The held result is the youngest value of its destination, so it overrides the file.
    always_comb begin
        op_a    = '0;
        rs2_val = '0;
        if (in_rs1 != '0) begin
            if (wb_valid && wb_wr_en && (wb_rd == in_rs1)) op_a = wb_data;
            else                                          op_a = rf[in_rs1];
        end
        if (in_rs2 != '0) begin
            if (wb_valid && wb_wr_en && (wb_rd == in_rs2)) rs2_val = wb_data;
            else                                          rs2_val = rf[in_rs2];
        end
        op_b = in_rd2_imme_sel ? rs2_val : in_imm;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        shamt      = op_b[SH_W-1:0];
        alu_result = '0;
        case (in_opcode)
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_SLL:  alu_result = op_a << shamt;
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_SRL:  alu_result = op_a >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
            OP_OR:   alu_result = op_a | op_b;
            OP_AND:  alu_result = op_a & op_b;
            default: alu_result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_wr_en <= 1'b0;
        end else if (accept) begin
            wb_valid <= 1'b1;
            wb_data  <= alu_result;
            wb_rd    <= in_rd;
            wb_wr_en <= in_rd_wr_en;
        end else if (commit) begin
            wb_valid <= 1'b0;
        end
    end

    // NOTE: the register file is architecturally cleared by reset, so it is built from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (commit && wb_wr_en && (wb_rd != '0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       retired_cnt <= '0;
        else if (commit) retired_cnt <= retired_cnt + 1'b1;
    end

    assign res_valid = wb_valid;
    assign res_data  = wb_data;
    assign res_rd    = wb_rd;
    assign op_done   = commit;
    assign dbg_data  = (dbg_addr == '0) ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_exec_pipe_v3.sv
// Bench for exec_pipe_v3: sequential-semantics model checked every cycle on the default
// build, plus directed literal checks on a small XLEN=16 / NUM_REGS=8 / CNT_W=4 build.
module tb_exec_pipe_v3;

    localparam int AW  = 5;
    localparam int SAW = 3;

    localparam int ADD = 0, SUB = 8, SLL = 1, SLT = 2, SLTU = 3;
    localparam int XOR = 4, SRL = 5, SRA = 13, OR = 6, AND = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- default build ----------------
    logic          reset;
    logic          in_valid, in_ready;
    logic [3:0]    in_opcode;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [31:0]   in_imm;
    logic          in_rd2_imme_sel, in_rd_wr_en;
    logic          res_valid, res_ready;
    logic [31:0]   res_data;
    logic [AW-1:0] res_rd;
    logic          op_done;
    logic [15:0]   retired_cnt;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_data;

    exec_pipe_v3 #(.XLEN(32), .NUM_REGS(32), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .in_rd2_imme_sel(in_rd2_imme_sel), .in_rd_wr_en(in_rd_wr_en),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
        .op_done(op_done), .retired_cnt(retired_cnt),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ---------------- small build ----------------
    logic           s_reset;
    logic           s_in_valid, s_in_ready;
    logic [3:0]     s_in_opcode;
    logic [SAW-1:0] s_in_rs1, s_in_rs2, s_in_rd;
    logic [15:0]    s_in_imm;
    logic           s_in_rd2_imme_sel, s_in_rd_wr_en;
    logic           s_res_valid, s_res_ready;
    logic [15:0]    s_res_data;
    logic [SAW-1:0] s_res_rd;
    logic           s_op_done;
    logic [3:0]     s_retired_cnt;
    logic [SAW-1:0] s_dbg_addr;
    logic [15:0]    s_dbg_data;

    exec_pipe_v3 #(.XLEN(16), .NUM_REGS(8), .CNT_W(4)) u_small (
        .clk(clk), .reset(s_reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_opcode(s_in_opcode),
        .in_rs1(s_in_rs1), .in_rs2(s_in_rs2), .in_rd(s_in_rd), .in_imm(s_in_imm),
        .in_rd2_imme_sel(s_in_rd2_imme_sel), .in_rd_wr_en(s_in_rd_wr_en),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_data(s_res_data), .res_rd(s_res_rd),
        .op_done(s_op_done), .retired_cnt(s_retired_cnt),
        .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (default build) ----------------
    // Architectural view: one optional pending result plus the committed register array.
    logic [31:0]   m_rf [32];
    logic          m_v = 1'b0;
    logic [31:0]   m_data = '0;
    logic [AW-1:0] m_rd = '0;
    logic          m_we = 1'b0;
    logic [15:0]   m_cnt = '0;
    logic          m_commit, m_accept;
    logic [31:0]   m_a, m_b, m_r;

    initial foreach (m_rf[i]) m_rf[i] = '0;

    // Latest value of a register in program order; r0 is always zero.
    function automatic logic [31:0] m_read(input logic [AW-1:0] r);
        if (r == 0) return 32'h0;
        if (m_v && m_we && m_rd == r) return m_data;
        return m_rf[r];
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (int'(op))
            ADD:     return a + b;
            SUB:     return a - b;
            SLL:     return a << sh;
            SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:    return (a < b) ? 32'd1 : 32'd0;
            XOR:     return a ^ b;
            SRL:     return a >> sh;
            SRA:     return $signed(a) >>> sh;
            OR:      return a | b;
            AND:     return a & b;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_v = 1'b0; m_data = '0; m_rd = '0; m_we = 1'b0; m_cnt = '0;
            foreach (m_rf[i]) m_rf[i] = '0;
        end else begin
            m_commit = m_v && res_ready;
            m_accept = in_valid && (!m_v || res_ready);
            if (m_accept) begin
                m_a = m_read(in_rs1);
                m_b = in_rd2_imme_sel ? m_read(in_rs2) : in_imm;
                m_r = m_alu(in_opcode, m_a, m_b);
            end
            if (m_commit) begin
                if (m_we && m_rd != 0) m_rf[m_rd] = m_data;
                m_cnt = m_cnt + 16'd1;
            end
            if (m_accept) begin
                m_v = 1'b1; m_data = m_r; m_rd = in_rd; m_we = in_rd_wr_en;
            end else if (m_commit) begin
                m_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, !m_v || res_ready);
        check("res_valid", res_valid, m_v);
        if (m_v) begin
            check("res_data", res_data, m_data);
            check("res_rd", res_rd, m_rd);
        end
        check("op_done", op_done, m_v && res_ready);
        check("retired_cnt", retired_cnt, m_cnt);
        check("dbg_data", dbg_data, (dbg_addr == 0) ? 32'h0 : m_rf[dbg_addr]);
    end

    // ---------------- drivers ----------------
    task automatic drive(input int op, input int rs1, input int rs2, input int rd,
                         input logic [31:0] imm, input logic sel, input logic we);
        in_opcode = 4'(op); in_rs1 = AW'(rs1); in_rs2 = AW'(rs2); in_rd = AW'(rd);
        in_imm = imm; in_rd2_imme_sel = sel; in_rd_wr_en = we; in_valid = 1'b1;
    endtask

    // Returns 1 time unit after the edge that accepted the op; inputs stay asserted.
    task automatic issue(input int op, input int rs1, input int rs2, input int rd,
                         input logic [31:0] imm, input logic sel, input logic we);
        logic acc;
        acc = 1'b0;
        drive(op, rs1, rs2, rd, imm, sel, we);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic issue_chk(input int op, input int rs1, input int rs2, input int rd,
                             input logic [31:0] imm, input logic sel, input logic [31:0] exp,
                             input string name);
        issue(op, rs1, rs2, rd, imm, sel, 1'b1);
        check(name, res_data, exp);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic s_issue(input int op, input int rs1, input int rd, input logic [15:0] imm);
        logic acc;
        acc = 1'b0;
        s_in_opcode = 4'(op); s_in_rs1 = SAW'(rs1); s_in_rs2 = '0; s_in_rd = SAW'(rd);
        s_in_imm = imm; s_in_rd2_imme_sel = 1'b0; s_in_rd_wr_en = 1'b1; s_in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = s_in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL s_issue_timeout: in_ready stayed 0, expected 1 within 20 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
        in_rd2_imme_sel = 0; in_rd_wr_en = 0; res_ready = 0; dbg_addr = '0;
        s_in_valid = 0; s_in_opcode = '0; s_in_rs1 = '0; s_in_rs2 = '0; s_in_rd = '0;
        s_in_imm = '0; s_in_rd2_imme_sel = 0; s_in_rd_wr_en = 0; s_res_ready = 0; s_dbg_addr = '0;
        reset = 0; s_reset = 0;
        #1 reset = 1; s_reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0; s_reset = 0;

        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_rd", res_rd, 0);
        check("rst_retired", retired_cnt, 0);

        // ADDI then a dependent ADD accepted in the commit cycle
        res_ready = 1;
        issue_chk(ADD, 0, 0, 1, 32'd5, 1'b0, 32'd5, "addi_r1");
        check("addi_op_done", op_done, 1);
        issue_chk(ADD, 1, 1, 2, 32'd0, 1'b1, 32'd10, "fwd_add");
        dbg_addr = 5'd1;
        #1 check("dbg_r1", dbg_data, 32'd5);
        check("cnt_after_addi", retired_cnt, 1);
        idle(1);

        // Backpressure: result 7 held three cycles with the next op waiting
        res_ready = 0;
        issue_chk(ADD, 0, 0, 3, 32'd7, 1'b0, 32'd7, "bp_first");
        drive(ADD, 3, 0, 4, 32'd1, 1'b0, 1'b1);
        dbg_addr = 5'd3;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_res_data", res_data, 32'd7);
            check("bp_dbg_r3", dbg_data, 32'd0);
        end
        #1 res_ready = 1;
        #1 check("bp_op_done", op_done, 1);
        check("bp_in_ready_rel", in_ready, 1);
        @(posedge clk);
        #1 check("bp_next", res_data, 32'd8);
        check("bp_dbg_r3_after", dbg_data, 32'd7);
        idle(1);

        // Arithmetic edges
        issue(ADD, 0, 0, 5, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(ADD, 0, 0, 6, 32'h1, 1'b0, 1'b1);
        issue(ADD, 0, 0, 7, 32'h8000_0000, 1'b0, 1'b1);
        issue_chk(SUB, 0, 6, 8, 32'h0, 1'b1, 32'hFFFF_FFFF, "sub_0_1");
        issue_chk(SLT, 5, 6, 9, 32'h0, 1'b1, 32'h1, "slt_m1_1");
        issue_chk(SLTU, 5, 6, 10, 32'h0, 1'b1, 32'h0, "sltu_max_1");
        issue_chk(SRA, 7, 0, 11, 32'd31, 1'b0, 32'hFFFF_FFFF, "sra_31");
        issue_chk(SLL, 6, 0, 12, 32'd33, 1'b0, 32'h2, "sll_33");
        issue_chk(SRL, 7, 0, 13, 32'd4, 1'b0, 32'h0800_0000, "srl_4");
        issue_chk(XOR, 5, 0, 14, 32'h0000_0F0F, 1'b0, 32'hFFFF_F0F0, "xor");
        issue_chk(OR, 6, 0, 15, 32'h10, 1'b0, 32'h11, "or");
        issue_chk(AND, 5, 7, 16, 32'h0, 1'b1, 32'h8000_0000, "and");
        issue_chk(ADD, 16, 16, 17, 32'h0, 1'b1, 32'h0, "add_wrap");

        // rd 0 and illegal opcodes
        issue_chk(ADD, 6, 0, 0, 32'd9, 1'b0, 32'd10, "rd0_result");
        issue_chk(15, 5, 6, 18, 32'h0, 1'b1, 32'h0, "illegal_f");
        check("rd0_op_done", op_done, 1);
        issue_chk(9, 5, 6, 19, 32'h0, 1'b1, 32'h0, "illegal_9");
        idle(2);
        check("cnt_20", retired_cnt, 20);
        dbg_addr = 5'd0;
        #1 check("dbg_r0", dbg_data, 32'h0);
        dbg_addr = 5'd4;
        #1 check("dbg_r4", dbg_data, 32'd8);

        // Reset while a result is held
        res_ready = 0;
        issue_chk(ADD, 0, 0, 20, 32'h55, 1'b0, 32'h55, "pre_rst");
        #1 reset = 1;
        dbg_addr = 5'd1;
        #1 check("mid_rst_valid", res_valid, 0);
        check("mid_rst_cnt", retired_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_dbg_r1", dbg_data, 32'h0);
        in_valid = 0;
        @(posedge clk);
        #1 reset = 0;
        dbg_addr = 5'd20;
        #1 check("mid_rst_no_commit", dbg_data, 32'h0);
        res_ready = 1;
        idle(2);

        // Small build: 16-bit wrap, counter wrap at 2^4, reset mid-operation
        s_res_ready = 1;
        s_issue(SUB, 0, 2, 16'h1);
        check("s_sub_wrap", s_res_data, 16'hFFFF);
        for (int i = 0; i < 16; i++) s_issue(ADD, 1, 1, 16'h1);
        check("s_r1_16", s_res_data, 16'h10);
        s_in_valid = 0;
        repeat (2) @(posedge clk);
        #1 check("s_cnt_wrap", s_retired_cnt, 4'd1);
        s_dbg_addr = 3'd1;
        #1 check("s_dbg_r1", s_dbg_data, 16'h10);
        s_res_ready = 0;
        s_issue(ADD, 0, 3, 16'h1234);
        check("s_held", s_res_data, 16'h1234);
        s_in_valid = 0;
        @(negedge clk);
        check("s_in_ready_bp", s_in_ready, 0);
        #1 s_reset = 1;
        s_dbg_addr = 3'd2;
        #1 check("s_rst_valid", s_res_valid, 0);
        check("s_rst_cnt", s_retired_cnt, 0);
        check("s_rst_dbg_r2", s_dbg_data, 16'h0);
        @(posedge clk);
        #1 s_reset = 0;
        s_dbg_addr = 3'd3;
        #1 check("s_rst_no_commit", s_dbg_data, 16'h0);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
